button_event_ctrl: RTL

BUTTON_EVENT_CTRL -- requirements
Module: button_event_ctrl

---
 rtl/button_event_ctrl_if.sv | 37 +++
 rtl/button_event_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_ctrl_if.sv
// -----------------------------------------------------------------------------
// button_event_ctrl_if
// Bus bundle for button_event_ctrl. It carries two buses:
//   polled side (controller -> button peripheral)
//     btn_rd     1          read strobe to the peripheral
//     btn_raddr  ADDRWIDTH  read address to the peripheral
//     btn_rdata  32         peripheral read data, valid the cycle after btn_rd
//   host side (CPU -> controller)
//     rd         1          host read strobe
//     raddr      ADDRWIDTH  host read address
//     rdata      32         host read data, registered
//     irq        1          high while the event FIFO is non-empty
// Modports:
//   master  the controller's view (drives the poll strobe and host read data)
//   slave   the surrounding system's view (peripheral plus host)
// -----------------------------------------------------------------------------
interface button_event_ctrl_if #(
  parameter int ADDRWIDTH = 4
);
  logic                 btn_rd;
  logic [ADDRWIDTH-1:0] btn_raddr;
  logic [31:0]          btn_rdata;
  logic                 rd;
  logic [ADDRWIDTH-1:0] raddr;
  logic [31:0]          rdata;
  logic                 irq;

  modport master (
    output btn_rd, btn_raddr, rdata, irq,
    input  btn_rdata, rd, raddr
  );

  modport slave (
    input  btn_rd, btn_raddr, rdata, irq,
    output btn_rdata, rd, raddr
  );
endinterface

// File: rtl/button_event_ctrl.sv
// -----------------------------------------------------------------------------
// button_event_ctrl
// Polls an 8-button peripheral every POLL_DIV cycles, turns level changes into
// PRESS / RELEASE (and optionally REPEAT) events, queues them in an 8-entry
// FIFO and exposes them through a small host register file.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    button_event_ctrl_if.master (polled bus + host bus + irq)
//
// Host registers:
//   0x00 EVENT   {1, 26'h0, event[4:0]} and pops; 0 when empty (no pop)
//   0x04 STATUS  {23'h0, overflow, 4'h0, count[3:0]}; clears overflow on read
//   0x08 LEVEL   {24'h0, debounced levels from the last completed scan}
//
// Event encoding: [4:3] type (01 PRESS, 10 RELEASE, 11 REPEAT), [2:0] button.
//
// Optional feature: define BTN_EVENT_REPEAT_EN to build the per-button hold
// counters and REPEAT events. Without it LONG_TICKS/REPEAT_TICKS are ignored.
// -----------------------------------------------------------------------------
module button_event_ctrl #(
  parameter int ADDRWIDTH    = 4,
  parameter int POLL_DIV     = 50000,
  parameter int LONG_TICKS   = 800,
  parameter int REPEAT_TICKS = 200
) (
  input  logic                clk,
  input  logic                rst_n,
  button_event_ctrl_if.master bus
);

  localparam int                   PW         = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [PW-1:0]        PRESC_LAST = PW'(POLL_DIV - 1);
  localparam logic [ADDRWIDTH-1:0] A_EVENT    = ADDRWIDTH'(0);
  localparam logic [ADDRWIDTH-1:0] A_STATUS   = ADDRWIDTH'(4);
  localparam logic [ADDRWIDTH-1:0] A_LEVEL    = ADDRWIDTH'(8);
  localparam logic [ADDRWIDTH-1:0] A_BTN      = ADDRWIDTH'(4);
  localparam logic [1:0]           EV_PRESS   = 2'b01;
  localparam logic [1:0]           EV_RELEASE = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_CAPT, S_SCAN} state_t;

  state_t               r_state;
  logic [PW-1:0]        r_presc;
  logic [7:0]           r_prev;
  logic [7:0]           r_cur;
  logic [2:0]           r_idx;
  logic                 r_first;
  logic                 r_btn_rd;
  logic [ADDRWIDTH-1:0] r_btn_raddr;

  logic [4:0]           r_mem [8];
  logic [2:0]           r_wr_ptr;
  logic [2:0]           r_rd_ptr;
  logic [3:0]           r_count;
  logic                 r_ovf;
  logic [31:0]          r_rdata;

  logic                 w_tick;
  logic                 w_push;
  logic [4:0]           w_evt;
  logic                 w_pop;
  logic                 w_push_ok;
  logic [31:0]          w_rdata_nxt;

  assign w_tick = (r_presc == PRESC_LAST);

`ifdef BTN_EVENT_REPEAT_EN
  localparam logic [9:0] HOLD_MAX  = 10'd1023;
  localparam logic [9:0] LONG_V    = 10'(LONG_TICKS);
  localparam logic [9:0] REP_V     = 10'(REPEAT_TICKS);
  localparam logic [1:0] EV_REPEAT = 2'b11;

  logic [9:0] r_hold [8];
  logic [9:0] w_hold_nxt;
  logic       w_hold_inc;
  logic       w_rep_hit;
  logic       w_unused;

  assign w_unused = ^bus.btn_rdata[31:8];

  // A repeat fires only on a poll that actually advances the hold count, so a
  // saturated counter stops repeating instead of firing every poll.
  always_comb begin
    w_hold_inc = (r_hold[r_idx] != HOLD_MAX);
    w_hold_nxt = r_hold[r_idx] + 10'd1;
    w_rep_hit  = w_hold_inc &&
                 ((w_hold_nxt == LONG_V) ||
                  ((w_hold_nxt > LONG_V) && (((w_hold_nxt - LONG_V) % REP_V) == 10'd0)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) r_hold[i] <= '0;
    end else if (r_state == S_SCAN && r_cur[r_idx]) begin
      if (!r_prev[r_idx])  r_hold[r_idx] <= '0;
      else if (w_hold_inc) r_hold[r_idx] <= w_hold_nxt;
    end
  end
`else
  logic w_unused;

  assign w_unused = ^{bus.btn_rdata[31:8], 32'(LONG_TICKS), 32'(REPEAT_TICKS)};
`endif

  // Edge detect for the button currently being scanned; one event at most.
  // NOTE: every variable driven here gets a default first, so no latch is inferred.
  always_comb begin
    w_push = 1'b0;
    w_evt  = '0;
    if (r_state == S_SCAN) begin
      case ({r_prev[r_idx], r_cur[r_idx]})
        2'b01: begin w_push = 1'b1; w_evt = {EV_PRESS, r_idx};   end
        2'b10: begin w_push = 1'b1; w_evt = {EV_RELEASE, r_idx}; end
`ifdef BTN_EVENT_REPEAT_EN
        2'b11: begin w_push = w_rep_hit; w_evt = {EV_REPEAT, r_idx}; end
`endif
        default: ;
      endcase
    end
  end

  // Poll sequencer. The peripheral presents data only in the cycle after the
  // strobe, so it is sampled on the WAIT->CAPT edge; CAPT then either seeds
  // prev (first poll after reset, no events) or starts the 8-cycle scan.
  // NOTE: all registered state uses non-blocking assignments so every block sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_presc     <= '0;
      r_prev      <= '0;
      r_cur       <= '0;
      r_idx       <= '0;
      r_first     <= 1'b1;
      r_btn_rd    <= 1'b0;
      r_btn_raddr <= '0;
    end else begin
      r_presc  <= w_tick ? '0 : r_presc + PW'(1);
      r_btn_rd <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_tick) begin
            r_state     <= S_REQ;
            r_btn_rd    <= 1'b1;
            r_btn_raddr <= A_BTN;
          end
        end
        S_REQ:  r_state <= S_WAIT;
        S_WAIT: begin
          r_cur   <= bus.btn_rdata[7:0];
          r_state <= S_CAPT;
        end
        S_CAPT: begin
          if (r_first) begin
            r_prev  <= r_cur;
            r_first <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_idx   <= '0;
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          r_prev[r_idx] <= r_cur[r_idx];
          r_idx         <= r_idx + 3'd1;
          if (r_idx == 3'd7) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A pop only happens on an EVENT read of a non-empty FIFO; a push into a
  // full FIFO still succeeds when a pop frees a slot in the same cycle.
  assign w_pop     = bus.rd && (bus.raddr == A_EVENT) && (r_count != 4'd0);
  assign w_push_ok = w_push && (!r_count[3] || w_pop);

  always_comb begin
    w_rdata_nxt = '0;
    case (bus.raddr)
      A_EVENT:  if (r_count != 4'd0) w_rdata_nxt = {1'b1, 26'h0, r_mem[r_rd_ptr]};
      A_STATUS: w_rdata_nxt = {23'h0, r_ovf, 4'h0, r_count};
      A_LEVEL:  w_rdata_nxt = {24'h0, r_prev};
      default:  ;
    endcase
  end

  // NOTE: the FIFO storage array is not reset; count/pointers guard its contents.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= w_evt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 3'd1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 3'd1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: ;
      endcase
      // Set is evaluated after the read-clear so a drop in the same cycle sticks.
      if (bus.rd && (bus.raddr == A_STATUS)) r_ovf <= 1'b0;
      if (w_push && !w_push_ok)              r_ovf <= 1'b1;
      if (bus.rd) r_rdata <= w_rdata_nxt;
    end
  end

  assign bus.btn_rd    = r_btn_rd;
  assign bus.btn_raddr = r_btn_raddr;
  assign bus.rdata     = r_rdata;
  assign bus.irq       = (r_count != 4'd0);

endmodule
